// File: rtl/pe_rcf_pkg.sv
// pe_rcf_pkg: shared mode encodings, FSM states and default widths for the PE job sequencer
package pe_rcf_pkg;
   localparam int PE_LAT_DEF = 1;
   localparam int LEN_W_DEF  = 8;
   localparam int ACC_W_DEF  = 40;
   localparam logic [1:0] MODE_M0   = 2'b00;
   localparam logic [1:0] MODE_M1   = 2'b01;
   localparam logic [1:0] MODE_M2   = 2'b10;
   localparam logic [1:0] MODE_IDLE = 2'b11;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
endpackage

// File: rtl/pe_inflight_sr.sv
// pe_inflight_sr: valid-bit delay line tracking operand pairs still inside the PE pipeline
module pe_inflight_sr #(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic vld_i,
   output logic vld_o,
   output logic empty_o
);
   logic [DEPTH-1:0] sr_q, sr_d;
   // shift the new valid bit in at position 0
   always_comb begin
      sr_d    = sr_q << 1;
      sr_d[0] = vld_i;
   end
   // delay-line register, cleared on reset so an abandoned job leaves nothing in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sr_q <= '0;
      else        sr_q <= sr_d;
   end
   assign vld_o   = sr_q[DEPTH-1];
   assign empty_o = ~|sr_q;
endmodule

// File: rtl/pe_rcf_sched.sv
// pe_rcf_sched: streams a job's operand pairs into the PE, accumulates its results and returns the sum
module pe_rcf_sched
   import pe_rcf_pkg::*;
#(
   parameter int PE_LAT = PE_LAT_DEF,
   parameter int LEN_W  = LEN_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_mode,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [15:0]      op_a,
   input  logic [15:0]      op_b,
   output logic [1:0]       pe_mode,
   output logic [15:0]      pe_mult0,
   output logic [15:0]      pe_mult1,
   input  logic [31:0]      pe_result,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [ACC_W-1:0] res_acc,
   output logic [LEN_W-1:0] res_count,
   output logic             busy
);
   state_e           state_q;
   logic [LEN_W-1:0] len_q, iss_q, cnt_q;
   logic [ACC_W-1:0] acc_q;
   logic [1:0]       mode_q;
   logic [15:0]      mult0_q, mult1_q;
   logic             res_valid_q, ret_q, sr_out, sr_empty, op_fire;
   assign cmd_ready = state_q == IDLE;
   assign op_ready  = state_q == RUN && iss_q < len_q;
   assign op_fire   = op_ready && op_valid;
   assign busy      = state_q != IDLE;
   assign pe_mode   = mode_q;
   assign pe_mult0  = mult0_q;
   assign pe_mult1  = mult1_q;
   assign res_valid = res_valid_q;
   assign res_acc   = acc_q;
   assign res_count = cnt_q;
   pe_inflight_sr #(.DEPTH(PE_LAT)) u_sr (
      .clk     (clk),
      .rst_n   (rst_n),
      .vld_i   (op_fire),
      .vld_o   (sr_out),
      .empty_o (sr_empty)
   );
   // job FSM; ret_q delays the in-flight output by one cycle so the add samples pe_result once it is valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         len_q       <= '0;
         iss_q       <= '0;
         cnt_q       <= '0;
         acc_q       <= '0;
         mode_q      <= MODE_IDLE;
         mult0_q     <= '0;
         mult1_q     <= '0;
         res_valid_q <= 1'b0;
         ret_q       <= 1'b0;
      end else begin
         ret_q <= sr_out;
         if (ret_q) begin
            acc_q <= acc_q + ACC_W'(pe_result);
            cnt_q <= cnt_q + LEN_W'(1);
         end
         case (state_q)
            IDLE: if (cmd_valid) begin
               mode_q      <= cmd_mode;
               len_q       <= cmd_len;
               iss_q       <= '0;
               acc_q       <= '0;
               cnt_q       <= '0;
               state_q     <= cmd_len == '0 ? DONE : RUN;
               res_valid_q <= cmd_len == '0;
            end
            RUN: if (op_fire) begin
               mult0_q <= op_a;
               mult1_q <= op_b;
               iss_q   <= iss_q + LEN_W'(1);
               if (iss_q + LEN_W'(1) == len_q) state_q <= DRAIN;
            end
            DRAIN: if (sr_empty) begin
               state_q     <= DONE;
               res_valid_q <= 1'b1;
            end
            DONE: if (res_ready) begin
               state_q     <= IDLE;
               res_valid_q <= 1'b0;
               mode_q      <= MODE_IDLE;
               mult0_q     <= '0;
               mult1_q     <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pe_rcf_sched.sv
// tb_pe_rcf_sched: directed checks of the PE job sequencer at PE_LAT=1 and PE_LAT=3
module tb_pe_rcf_sched;
   logic clk = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   for (genvar g = 0; g < 2; g++) begin : lat
      localparam int L = (g == 0) ? 1 : 3;
      logic        rst_n = 1'b0, cmd_valid = 1'b0, op_valid = 1'b0, res_ready = 1'b0, fin = 1'b0;
      logic [1:0]  cmd_mode = 2'b00;
      logic [7:0]  cmd_len = 8'd0;
      logic [15:0] op_a = 16'd0, op_b = 16'd0;
      logic        cmd_ready, op_ready, res_valid, busy;
      logic [1:0]  pe_mode;
      logic [15:0] pe_mult0, pe_mult1;
      logic [31:0] pe_result;
      logic [39:0] res_acc;
      logic [7:0]  res_count;
      logic [31:0] st [L];
      logic [15:0] va [256];
      logic [15:0] vb [256];
      pe_rcf_sched #(.PE_LAT(L), .LEN_W(8), .ACC_W(40)) u_dut (
         .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
         .cmd_mode(cmd_mode), .cmd_len(cmd_len), .op_valid(op_valid), .op_ready(op_ready),
         .op_a(op_a), .op_b(op_b), .pe_mode(pe_mode), .pe_mult0(pe_mult0), .pe_mult1(pe_mult1),
         .pe_result(pe_result), .res_valid(res_valid), .res_ready(res_ready),
         .res_acc(res_acc), .res_count(res_count), .busy(busy)
      );
      // PE stub: unsigned product through L register stages
      always @(posedge clk) begin
         st[0] <= 32'(pe_mult0) * 32'(pe_mult1);
         for (int k = 1; k < L; k++) st[k] <= st[k-1];
      end
      assign pe_result = st[L-1];
      task automatic job(input logic [1:0] m, input int n, input bit bub, input int hold,
                         output logic [39:0] acc, output logic [7:0] cnt, output int lat_v,
                         output bit saw_rdy, output int errs);
         int i = 0;
         int cyc = 0;
         bit rdy;
         errs = 0;
         saw_rdy = 1'b0;
         @(negedge clk);
         cmd_mode = m; cmd_len = 8'(n); cmd_valid = 1'b1;
         chk($sformatf("L%0d cmd_ready idle", L), cmd_ready, 1);
         @(negedge clk);
         cmd_valid = 1'b0;
         while (i < n && cyc < 4000) begin
            op_valid = !(bub && cyc[0]);
            op_a = va[i]; op_b = vb[i];
            if (pe_mode !== m) errs++;
            saw_rdy |= op_ready;
            rdy = op_ready;
            @(negedge clk);
            cyc++;
            if (op_valid && rdy) i++;
         end
         op_valid = 1'b0;
         lat_v = 0;
         while (!res_valid && lat_v < 100) begin
            if (pe_mode !== m) errs++;
            saw_rdy |= op_ready;
            @(negedge clk);
            lat_v++;
         end
         chk($sformatf("L%0d res_valid", L), res_valid, 1);
         saw_rdy |= op_ready;
         acc = res_acc;
         cnt = res_count;
         repeat (hold) begin
            @(negedge clk);
            if (res_acc !== acc || res_valid !== 1'b1 || pe_mode !== m || cmd_ready !== 1'b0) errs++;
         end
         res_ready = 1'b1;
         @(negedge clk);
         res_ready = 1'b0;
         chk($sformatf("L%0d idle after res", L), {cmd_ready, res_valid, pe_mode, busy, pe_mult0, pe_mult1},
             {1'b1, 1'b0, 2'b11, 1'b0, 32'd0});
      endtask
      initial begin
         logic [39:0] acc;
         logic [7:0]  cnt;
         int          lv, errs;
         bit          sr;
         repeat (3) @(negedge clk);
         chk($sformatf("L%0d reset mode", L), pe_mode, 2'b11);
         chk($sformatf("L%0d reset mults", L), {pe_mult0, pe_mult1}, 32'd0);
         chk($sformatf("L%0d reset res", L), {res_valid, res_acc, res_count}, 49'd0);
         chk($sformatf("L%0d reset busy/rdy", L), {busy, cmd_ready, op_ready}, 3'b010);
         rst_n = 1'b1;
         va[0] = 16'd2; va[1] = 16'd4; va[2] = 16'd6;
         vb[0] = 16'd3; vb[1] = 16'd5; vb[2] = 16'd7;
         job(2'b00, 3, 1'b0, 0, acc, cnt, lv, sr, errs);
         chk($sformatf("L%0d basic acc", L), acc, 40'd68);
         chk($sformatf("L%0d basic cnt", L), cnt, 8'd3);
         chk($sformatf("L%0d basic mode errs", L), errs, 0);
         job(2'b00, 3, 1'b1, 5, acc, cnt, lv, sr, errs);
         chk($sformatf("L%0d bubble acc", L), acc, 40'd68);
         chk($sformatf("L%0d bubble cnt", L), cnt, 8'd3);
         chk($sformatf("L%0d bubble hold errs", L), errs, 0);
         job(2'b01, 0, 1'b0, 2, acc, cnt, lv, sr, errs);
         chk($sformatf("L%0d zero acc/cnt", L), {acc, cnt}, 48'd0);
         chk($sformatf("L%0d zero latency", L), lv, 0);
         chk($sformatf("L%0d zero op_ready seen", L), sr, 0);
         chk($sformatf("L%0d zero hold errs", L), errs, 0);
         for (int k = 0; k < 256; k++) begin va[k] = 16'hFFFF; vb[k] = 16'hFFFF; end
         job(2'b10, 255, 1'b0, 0, acc, cnt, lv, sr, errs);
         chk($sformatf("L%0d max acc", L), acc, 40'd255 * 40'h00FFFE0001);
         chk($sformatf("L%0d max cnt", L), cnt, 8'd255);
         chk($sformatf("L%0d max mode errs", L), errs, 0);
         va[0] = 16'd9; vb[0] = 16'd9;
         @(negedge clk);
         cmd_mode = 2'b00; cmd_len = 8'd4; cmd_valid = 1'b1;
         @(negedge clk);
         cmd_valid = 1'b0; op_valid = 1'b1; op_a = 16'd9; op_b = 16'd9;
         repeat (2) @(negedge clk);
         op_valid = 1'b0;
         chk($sformatf("L%0d busy mid-job", L), {busy, op_ready}, 2'b11);
         rst_n = 1'b0;
         #1;
         chk($sformatf("L%0d rst mode", L), pe_mode, 2'b11);
         chk($sformatf("L%0d rst mults", L), {pe_mult0, pe_mult1}, 32'd0);
         chk($sformatf("L%0d rst res/busy", L), {res_valid, busy}, 2'b00);
         @(negedge clk);
         rst_n = 1'b1;
         va[0] = 16'h0111; vb[0] = 16'h0202;
         job(2'b00, 1, 1'b0, 0, acc, cnt, lv, sr, errs);
         chk($sformatf("L%0d post-rst acc", L), acc, 40'h0000022422);
         chk($sformatf("L%0d post-rst cnt", L), cnt, 8'd1);
         fin = 1'b1;
      end
   end
   initial begin
      int t = 0;
      while (!(lat[0].fin && lat[1].fin) && t < 50000) begin
         @(negedge clk);
         t++;
      end
      if (!(lat[0].fin && lat[1].fin)) chk("timeout", 0, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
